step_clk_ctrl: RTL
==================

Name: step_clk_ctrl

Overview:
Upstream clock-source stage for the single-step processor harness. It drives the processor clock input: the `clk_pb` single-step clock feeding the system instance.
- Synchronises and debounces a raw push-button, then emits one clean fixed-width `clk_pb` pulse per press.
- Alternatively, emits one pulse per slow `run_tick` edge (for example the 4-second clock) when free-run mode is selected.
- Also counts delivered steps, for display or debug.

Parameters:
- DB_COUNT, 500000: consecutive stable `clk` cycles required to accept a new button level (5 ms at 100 MHz); minimum 1.
- PULSE_HIGH, 50000: `clk` cycles `clk_pb` is held high per step; minimum 1.
- PULSE_LOW, 50000: guard cycles `clk_pb` is held low after each pulse before a new request is accepted; minimum 1.
- CNT_W, 16: width of `step_count`.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  asynchronous, active-high reset.
- button  input  1  raw, asynchronous, bouncing push-button.
- run_en  input  1  asynchronous mode select: 1 = free-run from `run_tick`, 0 = single-step from `button`.
- run_tick  input  1  asynchronous slow free-run clock; its rising edges request steps.
- clk_pb  output  1  generated processor clock.
- pb_db  output  1  debounced button level.
- busy  output  1  high while in HIGH or GUARD.
- step_count  output  CNT_W  number of `clk_pb` rising edges since reset.

Behaviour:
- Reset (asynchronous, `rst` = 1): all of the following are forced immediately and held while `rst` is high.
  - `clk_pb` = 0, `pb_db` = 0, `busy` = 0, `step_count` = 0.
  - FSM = IDLE; debounce counter = 0.
  - Synchroniser and edge-detect flops = 0.
- Reset asserted mid-pulse drops `clk_pb` at once; it does not wait for the next `clk` edge.
- Synchronisers: `button`, `run_en` and `run_tick` each pass through a 2-flop synchroniser. All internal logic uses only the synchronised versions.
- Debouncer:
  - The counter increments each cycle the synchronised button differs from `pb_db`, and clears to 0 on any cycle they match.
  - When the counter reaches DB_COUNT, `pb_db` toggles on that edge and the counter clears.
  - Pulses shorter than DB_COUNT cycles never change `pb_db`.
- Request sources:
  - step_req = rising edge of `pb_db` (registered previous value), qualified by synchronised `run_en` = 0.
  - run_req = rising edge of synchronised `run_tick`, qualified by synchronised `run_en` = 1.
  - Each request is a 1-cycle internal strobe.
- FSM states:
  - IDLE: on step_req or run_req, go to HIGH. `clk_pb` = 1 from the next cycle, and `step_count` increments on that same edge.
  - HIGH: `clk_pb` = 1 for exactly PULSE_HIGH cycles, then go to GUARD.
  - GUARD: `clk_pb` = 0 for exactly PULSE_LOW cycles, then go to IDLE.
- Requests arriving in HIGH or GUARD are dropped, not queued. One press always gives exactly one pulse; a press must be released (`pb_db` back to 0) before it can request again.
- Changing `run_en` mid-pulse does not truncate or extend the current pulse. The new mode applies only to requests seen in IDLE.
- Latency: a clean button rise first sampled on clk edge 0 gives:
  - `pb_db` = 1 after edge DB_COUNT+2;
  - `clk_pb` = 1 after edge DB_COUNT+4.
- `run_tick` rise sampled on edge 0 gives `clk_pb` = 1 after edge 4.
- `clk_pb` is a registered output with no combinational path from any input.
- `step_count` wraps from all-ones to 0 with no flag.
- `busy` = 1 exactly when the state is HIGH or GUARD, and is registered alongside the state.

Test Plan (DB_COUNT=4, PULSE_HIGH=3, PULSE_LOW=2, CNT_W=4):
- Reset mid-pulse: press `button` clean and hold; assert `rst` while `clk_pb` = 1 → `clk_pb`, `busy` and `step_count` go to 0 immediately; no pulse after `rst` is released while the button stays high until it is released and pressed again.
- Clean press, hold 20 cycles → `pb_db` rises 6 edges after the first sample; `clk_pb` high for exactly 3 cycles starting edge 8, then low; `step_count` = 1; holding longer produces no second pulse.
- Bounce: toggle `button` 1-3 cycles per level for 30 cycles, then hold high → `pb_db` stays 0 during bounce; exactly one `clk_pb` pulse after stable high; `step_count` +1.
- Free-run: `run_en` = 1, `run_tick` square wave period 20 cycles, `button` pressed repeatedly → one 3-cycle pulse per `run_tick` rise; button ignored; `step_count` advances once per tick.
- Drop during busy: `run_en` = 1, `run_tick` rising edges 3 cycles apart → second request lands in HIGH/GUARD and is dropped; `step_count` +1 only.
- Wrap: 17 pulses → `step_count` reads 0xF after 15 pulses, then 0x0 after 16 and 0x1 after 17.

Source files
------------

// File: rtl/step_clk_ctrl.sv
// rtl/step_clk_ctrl.sv - single-step processor clock source: debounced button or free-run tick to fixed-width clk_pb pulse
module step_clk_ctrl #(
    parameter int DB_COUNT   = 500000,
    parameter int PULSE_HIGH = 50000,
    parameter int PULSE_LOW  = 50000,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic             run_en,
    input  logic             run_tick,
    output logic             clk_pb,
    output logic             pb_db,
    output logic             busy,
    output logic [CNT_W-1:0] step_count
);

    localparam int DW   = $clog2(DB_COUNT + 1);
    localparam int PMAX = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
    localparam int PW   = $clog2(PMAX + 1);

    typedef enum logic [1:0] {IDLE, HIGH, GUARD} state_t;

    logic             btn_s1_q, btn_s2_q, en_s1_q, en_s2_q, tick_s1_q, tick_s2_q;
    logic             tick_q, tick_prev_q, pb_db_q, pb_prev_q;
    logic             vld1_q, vld2_q, arm_q, req_q;
    logic [DW-1:0]    db_cnt_q;
    state_t           state_q, state_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             clk_pb_q, clk_pb_d, busy_q, busy_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic             step_req, run_req;

    // A button already held when reset drops must not fire: arm only after the
    // synchronised button has been seen genuinely released.
    assign step_req = pb_db_q & ~pb_prev_q & arm_q & ~en_s2_q;
    assign run_req  = tick_q & ~tick_prev_q & en_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1_q    <= 1'b0;
            btn_s2_q    <= 1'b0;
            en_s1_q     <= 1'b0;
            en_s2_q     <= 1'b0;
            tick_s1_q   <= 1'b0;
            tick_s2_q   <= 1'b0;
            tick_q      <= 1'b0;
            tick_prev_q <= 1'b0;
            pb_db_q     <= 1'b0;
            pb_prev_q   <= 1'b0;
            vld1_q      <= 1'b0;
            vld2_q      <= 1'b0;
            arm_q       <= 1'b0;
            req_q       <= 1'b0;
            db_cnt_q    <= '0;
        end else begin
            btn_s1_q    <= button;
            btn_s2_q    <= btn_s1_q;
            en_s1_q     <= run_en;
            en_s2_q     <= en_s1_q;
            tick_s1_q   <= run_tick;
            tick_s2_q   <= tick_s1_q;
            tick_q      <= tick_s2_q;
            tick_prev_q <= tick_q;
            pb_prev_q   <= pb_db_q;
            vld1_q      <= 1'b1;
            vld2_q      <= vld1_q;
            arm_q       <= arm_q | (vld2_q & ~btn_s2_q & ~pb_db_q);
            req_q       <= step_req | run_req;
            if (btn_s2_q == pb_db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DW'(DB_COUNT)) begin
                pb_db_q  <= ~pb_db_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pcnt_q     <= '0;
            clk_pb_q   <= 1'b0;
            busy_q     <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            clk_pb_q   <= clk_pb_d;
            busy_q     <= busy_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        clk_pb_d   = clk_pb_q;
        busy_d     = busy_q;
        step_cnt_d = step_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_q) begin
                    state_d    = HIGH;
                    pcnt_d     = '0;
                    clk_pb_d   = 1'b1;
                    busy_d     = 1'b1;
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (pcnt_q == PW'(PULSE_HIGH - 1)) begin
                    state_d  = GUARD;
                    pcnt_d   = '0;
                    clk_pb_d = 1'b0;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            GUARD: begin
                if (pcnt_q == PW'(PULSE_LOW - 1)) begin
                    state_d = IDLE;
                    pcnt_d  = '0;
                    busy_d  = 1'b0;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                pcnt_d   = '0;
                clk_pb_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign clk_pb     = clk_pb_q;
    assign pb_db      = pb_db_q;
    assign busy       = busy_q;
    assign step_count = step_cnt_q;

endmodule
